fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC SHALL default to 32'h00000000; it is the first fetch address after reset.
REQ-002 Parameter TIMEOUT SHALL default to 16; it is the maximum number of cycles the unit waits for imem_ack.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-006 imem_addr  output  32  SHALL be the fetch address.
REQ-007 imem_ack  input  1  SHALL indicate that imem_rdata is valid this cycle.
REQ-008 imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-009 instruction  output  32  SHALL be the instruction presented to the execute core.
REQ-010 pc  output  32  SHALL be the pc of the presented instruction.
REQ-011 next_pc  input  32  SHALL be the next pc computed by the core.
REQ-012 instr_valid  output  1  SHALL be high when instruction is being executed this cycle.
REQ-013 halt  input  1  SHALL request suspension of fetching.
REQ-014 fault  output  1  SHALL flag a sticky fetch fault.
REQ-015 fault_addr  output  32  SHALL hold the pc that caused the fault.
REQ-016 instret  output  32  SHALL count retired instructions.

Function
REQ-017 The state machine SHALL have the states FETCH, EXEC, HALT and FAULT.
REQ-018 In FETCH: imem_req=1 and imem_addr=pc_q, both held stable until imem_ack is sampled high.
REQ-019 In FETCH, on an edge with imem_ack=1: ir<=imem_rdata, timeout counter cleared, next state EXEC.
REQ-020 In FETCH, on an edge with imem_ack=0: the timeout counter SHALL increment; when it reaches TIMEOUT-1, next state FAULT with fault_addr<=pc_q.
REQ-021 imem_ack while imem_req=0 SHALL be ignored.
REQ-022 EXEC SHALL last exactly one cycle: instr_valid=1, instruction=ir, pc=pc_q.
REQ-023 Outside EXEC: instr_valid=0 and instruction=32'h00000013 (NOP); pc=pc_q, so the core writes no state.
REQ-024 At the EXEC edge: pc_q<=next_pc and instret<=instret+1 (modulo 2^32, wraps to 0).
REQ-025 Leaving EXEC, the next state SHALL be selected in this priority order.
  - next_pc[1:0]!=0: FAULT, with fault_addr<=next_pc.
  - halt=1: HALT.
  - otherwise: FETCH.
REQ-026 halt SHALL NOT abort an outstanding FETCH; it takes effect only at the EXEC exit.
REQ-027 HALT SHALL exit to FETCH on the first edge with halt=0; imem_req=0 while in HALT.
REQ-028 FAULT SHALL be absorbing until reset: fault=1, imem_req=0, instr_valid=0.
REQ-029 Throughput with zero-wait memory (ack in the same cycle as req) SHALL be one instruction per 2 cycles.
REQ-030 next_pc equal to pc (self-loop) SHALL be legal; fetch repeats the same address.

Reset
REQ-031 While rst=0, the unit SHALL asynchronously hold:
  - state=FETCH, pc_q=RESET_PC, ir=32'h00000013;
  - instret=0, timeout counter=0;
  - fault=0, fault_addr=0.
REQ-032 After rst deasserts, imem_req SHALL be 1 with imem_addr=RESET_PC in the same cycle; outputs follow REQ-018/REQ-023.
REQ-033 Reset mid-FETCH SHALL drop imem_req immediately, and any in-flight ack SHALL be discarded; mid-EXEC, neither pc_q nor instret updates.

Structure
REQ-034 A shared package SHALL hold:
  - the state encoding (FETCH=2'd0, EXEC=2'd1, HALT=2'd2, FAULT=2'd3);
  - the NOP constant 32'h00000013;
  - the XLEN=32 constant.
REQ-035 The timeout counter SHALL be a sub-module fetch_timer (clear, enable, expired outputs, width $clog2(TIMEOUT)); everything else is in fetch_unit.

Verification
REQ-036 Zero-wait memory, rst released, next_pc=pc+4 -> imem_addr sequence 0,4,8; instr_valid every 2nd cycle; instret=3 after 6 cycles.
REQ-037 Ack delayed 3 cycles at addr 0x10 -> imem_addr=0x10 stable 4 cycles; instruction=NOP until EXEC; instr_valid high for 1 cycle.
REQ-038 No ack with TIMEOUT=16 -> FAULT after 16 FETCH cycles; fault=1, fault_addr=RESET_PC, imem_req=0 until reset.
REQ-039 next_pc=0x00000102 in EXEC -> fault=1, fault_addr=0x102 next cycle; no further requests.
REQ-040 halt=1 raised during a FETCH with 2-cycle ack latency -> that instruction still executes, then HALT; halt=0 -> FETCH at next_pc within 1 cycle.
REQ-041 rst asserted mid-FETCH with ack arriving in the same cycle -> pc=RESET_PC, instret=0, ir=NOP; the ack is discarded.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: datapath width,
// the canonical NOP word, the fetch state encoding and small helpers.
package fetch_unit_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- presented to the core whenever nothing executes
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_e;

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Fetch timeout counter: counts wait cycles of one outstanding fetch and
// reports when the last permitted wait cycle has been reached.
module fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_r;

    // Wait-cycle counter; saturates at LAST so it can never wrap back to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches one word per instruction from instruction
// memory, presents it to the execute core for exactly one cycle, and
// handles halting, fetch timeouts and misaligned-target faults.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    input  logic [31:0] next_pc,
    output logic        instr_valid,
    input  logic        halt,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] instret
);

    state_e            state_r;
    state_e            state_s;
    logic [XLEN-1:0]   pc_r;
    logic [XLEN-1:0]   ir_r;
    logic [XLEN-1:0]   instret_r;
    logic [XLEN-1:0]   fault_addr_r;
    logic              expired_s;
    logic              timer_clear_s;
    logic              timer_en_s;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (expired_s)
    );

    // Next-state selection and timer control for the fetch sequencer.
    always_comb begin
        state_s       = state_r;
        timer_clear_s = 1'b0;
        timer_en_s    = 1'b0;
        case (state_r)
            FETCH: begin
                if (imem_ack) begin
                    state_s       = EXEC;
                    timer_clear_s = 1'b1;
                end else if (expired_s) begin
                    state_s = FAULT;
                end else begin
                    timer_en_s = 1'b1;
                end
            end
            EXEC: begin
                timer_clear_s = 1'b1;
                if (is_misaligned(next_pc)) begin
                    state_s = FAULT;
                end else if (halt) begin
                    state_s = HALT;
                end else begin
                    state_s = FETCH;
                end
            end
            HALT: begin
                timer_clear_s = 1'b1;
                if (!halt) begin
                    state_s = FETCH;
                end else begin
                    state_s = HALT;
                end
            end
            FAULT: begin
                state_s = FAULT;
            end
            default: begin
                state_s = FAULT;
            end
        endcase
    end

    // State register; an unknown encoding can only be left through reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Architectural registers: pc, instruction register, retire count, fault address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r         <= RESET_PC;
            ir_r         <= NOP;
            instret_r    <= 32'd0;
            fault_addr_r <= 32'd0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (imem_ack) begin
                        ir_r <= imem_rdata;
                    end else if (expired_s) begin
                        fault_addr_r <= pc_r;
                    end else begin
                        ir_r <= ir_r;
                    end
                end
                EXEC: begin
                    pc_r      <= next_pc;
                    instret_r <= instret_r + 32'd1;
                    if (is_misaligned(next_pc)) begin
                        fault_addr_r <= next_pc;
                    end else begin
                        fault_addr_r <= fault_addr_r;
                    end
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

    // The request is gated by reset so it drops the instant reset asserts.
    assign imem_req    = (state_r == FETCH) && rst;
    assign imem_addr   = pc_r;
    assign instr_valid = (state_r == EXEC);
    assign instruction = (state_r == EXEC) ? ir_r : NOP;
    assign pc          = pc_r;
    assign fault       = (state_r == FAULT);
    assign fault_addr  = fault_addr_r;
    assign instret     = instret_r;

endmodule
